// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//
// Contents:
//   REG_ADDR_WIDTH   - register-file address width (x0..x31)
//   STALL_CNT_WIDTH  - width of the stall performance counter
//   HOLD / NOHOLD    - hold/flush output levels
//   RST              - active level of the asynchronous reset
//   pc_state_e       - controller states PC_IDLE / PC_MEM_WAIT
//   pc_ctrl_t        - bundle of hold/flush controls driven to the pipeline
//
// The optional memory-timeout feature is enabled by defining the macro
// PIPE_CTRL_TIMEOUT_EN (left undefined by default).
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_WIDTH  = 5;
    localparam int unsigned STALL_CNT_WIDTH = 32;

    localparam logic HOLD   = 1'b1;
    localparam logic NOHOLD = 1'b0;
    localparam logic RST    = 1'b0;

    typedef enum logic {
        PC_IDLE     = 1'b0,
        PC_MEM_WAIT = 1'b1
    } pc_state_e;

    typedef struct packed {
        logic hold_if;
        logic hold_id;
        logic hold_ex;
        logic flush_id;
        logic flush_ex;
    } pc_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID-stage source registers and the
// destination of a load sitting in EX. Purely combinational.
//
// Ports:
//   id_rs1_addr / id_rs2_addr  in   source register addresses in ID
//   id_rs1_ren  / id_rs2_ren   in   ID instruction actually reads rs1 / rs2
//   ex_rd_waddr                in   destination register of the EX instruction
//   ex_is_load                 in   EX instruction is a load
//   lu_hazard                  out  ID must wait one cycle for the load data
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_ren,
    input  logic                      id_rs2_ren,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_waddr,
    input  logic                      ex_is_load,
    output logic                      lu_hazard
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired to zero, so a load targeting it can never feed ID.
    always_comb begin
        rd_nonzero = (ex_rd_waddr != '0);
        rs1_hit    = id_rs1_ren && (id_rs1_addr == ex_rd_waddr);
        rs2_hit    = id_rs2_ren && (id_rs2_addr == ex_rd_waddr);
        lu_hazard  = ex_is_load && rd_nonzero && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: drives hold/flush of the IF/ID (fliop1),
// ID/EX (fliop2) and EX/MEM (fliop3) registers and counts stall cycles.
//
// Hazard priority (highest first): memory stall, taken branch, load-use.
// Holds and flushes are combinational from state and inputs so the
// pipeline registers act on them at the same edge.
//
// Parameters:
//   TIMEOUT    MEM_WAIT cycles allowed before mem_err (timeout build only)
//   CNT_WIDTH  width of the MEM_WAIT counter, 2**CNT_WIDTH > TIMEOUT
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_rs1/rs2_addr/_ren     ID-stage source operands
//   ex_rd_waddr, ex_is_load  EX-stage destination and load flag
//   ex_br_taken              EX resolved a taken branch/jump
//   mem_req, mem_ack         data-memory handshake of the MEM stage
//   hold_if/hold_id/hold_ex  freeze PC+fliop1 / fliop2 / fliop3
//   flush_id/flush_ex        load NOP into fliop1 / fliop2
//   stall_cnt                free-running count of cycles with hold_if=1
//   mem_err                  one-cycle pulse on memory timeout
//
// Build option: define PIPE_CTRL_TIMEOUT_EN to enable the MEM_WAIT timeout;
// without it mem_err is tied low and MEM_WAIT waits for mem_ack forever.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]  id_rs2_addr,
    input  logic                       id_rs1_ren,
    input  logic                       id_rs2_ren,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_rd_waddr,
    input  logic                       ex_is_load,
    input  logic                       ex_br_taken,
    input  logic                       mem_req,
    input  logic                       mem_ack,
    output logic                       hold_if,
    output logic                       hold_id,
    output logic                       hold_ex,
    output logic                       flush_id,
    output logic                       flush_ex,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
    output logic                       mem_err
);

    // Reject a counter too narrow to ever reach TIMEOUT.
    if ((CNT_WIDTH < 32) && (TIMEOUT >= (32'd1 << CNT_WIDTH))) begin : g_cfg_check
        $error("pipe_ctrl: CNT_WIDTH too small for TIMEOUT");
    end

    pc_state_e                  state_q;
    pc_state_e                  state_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_d;
    pc_ctrl_t                   ctrl_c;
    logic                       mem_err_c;
    logic                       mem_stall_c;
    logic                       timeout_hit_c;
    logic                       lu_hazard;

    hazard_detect u_hazard_detect (
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_ren  (id_rs1_ren),
        .id_rs2_ren  (id_rs2_ren),
        .ex_rd_waddr (ex_rd_waddr),
        .ex_is_load  (ex_is_load),
        .lu_hazard   (lu_hazard)
    );

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    logic [CNT_WIDTH-1:0] wait_cnt_q;
    logic [CNT_WIDTH-1:0] wait_cnt_d;

    // Held at zero in IDLE so it is already cleared on MEM_WAIT entry;
    // the compare against TIMEOUT-1 makes the TIMEOUT-th waiting cycle
    // after the request the one that fires.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == PC_MEM_WAIT) begin
            wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timeout_hit_c = (state_q == PC_MEM_WAIT) && !mem_ack
                           && (wait_cnt_q == TIMEOUT_LAST);
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Next state and hazard priority mux.
    always_comb begin
        state_d     = state_q;
        ctrl_c      = '0;
        mem_err_c   = 1'b0;
        mem_stall_c = 1'b0;

        // Once waiting, only the ack releases the stall; mem_req is not
        // re-qualified because the request is frozen in MEM.
        if (state_q == PC_IDLE) begin
            mem_stall_c = mem_req && !mem_ack;
        end else begin
            mem_stall_c = !mem_ack;
        end

        if (timeout_hit_c) begin
            mem_err_c = 1'b1;
            state_d   = PC_IDLE;
        end else if (mem_stall_c) begin
            ctrl_c.hold_if = HOLD;
            ctrl_c.hold_id = HOLD;
            ctrl_c.hold_ex = HOLD;
            state_d        = PC_MEM_WAIT;
        end else begin
            state_d = PC_IDLE;
        end

        // A branch held in a frozen EX fires here on the release cycle.
        if (!mem_stall_c || timeout_hit_c) begin
            if (ex_br_taken) begin
                ctrl_c.flush_id = HOLD;
                ctrl_c.flush_ex = HOLD;
            end else if (lu_hazard) begin
                ctrl_c.hold_if  = HOLD;
                ctrl_c.hold_id  = HOLD;
                ctrl_c.flush_ex = HOLD;
            end
        end

        // Outputs are forced quiet for the whole reset window.
        if (rst == RST) begin
            ctrl_c    = '0;
            mem_err_c = 1'b0;
        end
    end

    // Stall counter wraps naturally at 2**32.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl_c.hold_if == HOLD) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST) begin
            state_q     <= PC_IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hold_if   = ctrl_c.hold_if;
    assign hold_id   = ctrl_c.hold_id;
    assign hold_ex   = ctrl_c.hold_ex;
    assign flush_id  = ctrl_c.flush_id;
    assign flush_ex  = ctrl_c.flush_ex;
    assign mem_err   = mem_err_c;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl. Inputs change 1 time unit
// after the rising edge; combinational outputs are sampled 1 unit later,
// stall_cnt right after the edge that updates it.
// The timeout scenario is built only when PIPE_CTRL_TIMEOUT_EN is defined.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic                       clk;
    logic                       rst;
    logic [REG_ADDR_WIDTH-1:0]  id_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0]  id_rs2_addr;
    logic                       id_rs1_ren;
    logic                       id_rs2_ren;
    logic [REG_ADDR_WIDTH-1:0]  ex_rd_waddr;
    logic                       ex_is_load;
    logic                       ex_br_taken;
    logic                       mem_req;
    logic                       mem_ack;
    logic                       hold_if;
    logic                       hold_id;
    logic                       hold_ex;
    logic                       flush_id;
    logic                       flush_ex;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic                       mem_err;

    // {hold_if, hold_id, hold_ex, flush_id, flush_ex, mem_err}
    logic [5:0] outs;
    assign outs = {hold_if, hold_id, hold_ex, flush_id, flush_ex, mem_err};

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_cnt;

    pipe_ctrl #(
        .TIMEOUT   (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_ren  (id_rs1_ren),
        .id_rs2_ren  (id_rs2_ren),
        .ex_rd_waddr (ex_rd_waddr),
        .ex_is_load  (ex_is_load),
        .ex_br_taken (ex_br_taken),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .hold_if     (hold_if),
        .hold_id     (hold_id),
        .hold_ex     (hold_ex),
        .flush_id    (flush_id),
        .flush_ex    (flush_ex),
        .stall_cnt   (stall_cnt),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task clear_inputs;
        id_rs1_addr = '0;
        id_rs2_addr = '0;
        id_rs1_ren  = 1'b0;
        id_rs2_ren  = 1'b0;
        ex_rd_waddr = '0;
        ex_is_load  = 1'b0;
        ex_br_taken = 1'b0;
        mem_req     = 1'b0;
        mem_ack     = 1'b0;
    endtask

    task next_cycle;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        rst = 1'b0;
        clear_inputs();
        mem_req = 1'b1;
        ex_br_taken = 1'b1;
        ex_is_load = 1'b1; ex_rd_waddr = 5'd3; id_rs1_ren = 1'b1; id_rs1_addr = 5'd3;
        #2;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_outs got %b expected %b", outs, 6'b000000);
        end
        next_cycle();
        next_cycle();
        tests_run++;
        if (stall_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt got %0d expected 0", stall_cnt);
        end
        clear_inputs();
        rst = 1'b1;
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_release_outs got %b expected %b", outs, 6'b000000);
        end
        next_cycle();
        exp_cnt = 32'd0;
    endtask

    task test_load_use;
        clear_inputs();
        ex_is_load = 1'b1; ex_rd_waddr = 5'd5;
        id_rs2_ren = 1'b1; id_rs2_addr = 5'd5;
        id_rs1_ren = 1'b1; id_rs1_addr = 5'd3;
        #1;
        tests_run++;
        if (outs !== 6'b110010) begin
            tests_failed++;
            $display("FAIL lu_rs2_outs got %b expected %b", outs, 6'b110010);
        end
        next_cycle();
        exp_cnt = exp_cnt + 32'd1;
        clear_inputs();
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL lu_clear_outs got %b expected %b", outs, 6'b000000);
        end
        tests_run++;
        if (stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL lu_cnt got %0d expected %0d", stall_cnt, exp_cnt);
        end
    endtask

    task test_load_use_x0;
        clear_inputs();
        ex_is_load = 1'b1; ex_rd_waddr = 5'd0;
        id_rs2_ren = 1'b1; id_rs2_addr = 5'd0;
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL lu_x0_outs got %b expected %b", outs, 6'b000000);
        end
        // rs1 matches but is not read: no hazard
        ex_rd_waddr = 5'd7; id_rs2_ren = 1'b0; id_rs1_addr = 5'd7; id_rs1_ren = 1'b0;
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL lu_noren_outs got %b expected %b", outs, 6'b000000);
        end
        next_cycle();
        tests_run++;
        if (stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL lu_x0_cnt got %0d expected %0d", stall_cnt, exp_cnt);
        end
        id_rs1_ren = 1'b1;
        #1;
        tests_run++;
        if (outs !== 6'b110010) begin
            tests_failed++;
            $display("FAIL lu_rs1_outs got %b expected %b", outs, 6'b110010);
        end
        next_cycle();
        exp_cnt = exp_cnt + 32'd1;
        clear_inputs();
    endtask

    task test_branch;
        clear_inputs();
        ex_br_taken = 1'b1;
        #1;
        tests_run++;
        if (outs !== 6'b000110) begin
            tests_failed++;
            $display("FAIL branch_outs got %b expected %b", outs, 6'b000110);
        end
        next_cycle();
        clear_inputs();
        #1;
        tests_run++;
        if (stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL branch_cnt got %0d expected %0d", stall_cnt, exp_cnt);
        end
    endtask

    task test_branch_vs_load_use;
        clear_inputs();
        ex_br_taken = 1'b1;
        ex_is_load = 1'b1; ex_rd_waddr = 5'd9; id_rs1_ren = 1'b1; id_rs1_addr = 5'd9;
        #1;
        tests_run++;
        if (outs !== 6'b000110) begin
            tests_failed++;
            $display("FAIL br_lu_outs got %b expected %b", outs, 6'b000110);
        end
        next_cycle();
        clear_inputs();
    endtask

    task test_mem_wait;
        clear_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (outs !== 6'b111000) begin
                tests_failed++;
                $display("FAIL mem_wait_outs cycle %0d got %b expected %b", i, outs, 6'b111000);
            end
            next_cycle();
            exp_cnt = exp_cnt + 32'd1;
        end
        mem_ack = 1'b1;
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL mem_ack_outs got %b expected %b", outs, 6'b000000);
        end
        next_cycle();
        clear_inputs();
        // Back in IDLE: no request means no hold
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL mem_idle_outs got %b expected %b", outs, 6'b000000);
        end
        tests_run++;
        if (stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL mem_wait_cnt got %0d expected %0d", stall_cnt, exp_cnt);
        end
    endtask

    task test_mem_ack_same_cycle;
        clear_inputs();
        mem_req = 1'b1; mem_ack = 1'b1;
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL ack_same_outs got %b expected %b", outs, 6'b000000);
        end
        next_cycle();
        clear_inputs();
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL ack_same_idle_outs got %b expected %b", outs, 6'b000000);
        end
        tests_run++;
        if (stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL ack_same_cnt got %0d expected %0d", stall_cnt, exp_cnt);
        end
    endtask

    task test_branch_during_wait;
        clear_inputs();
        ex_br_taken = 1'b1;
        mem_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (outs !== 6'b111000) begin
                tests_failed++;
                $display("FAIL br_wait_outs cycle %0d got %b expected %b", i, outs, 6'b111000);
            end
            next_cycle();
            exp_cnt = exp_cnt + 32'd1;
        end
        mem_ack = 1'b1;
        #1;
        tests_run++;
        if (outs !== 6'b000110) begin
            tests_failed++;
            $display("FAIL br_release_outs got %b expected %b", outs, 6'b000110);
        end
        next_cycle();
        clear_inputs();
        #1;
        tests_run++;
        if (stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL br_wait_cnt got %0d expected %0d", stall_cnt, exp_cnt);
        end
    endtask

    task test_reset_mid_wait;
        clear_inputs();
        mem_req = 1'b1;
        next_cycle();
        exp_cnt = exp_cnt + 32'd1;
        #1;
        tests_run++;
        if (outs !== 6'b111000 || stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL pre_reset_wait got outs %b cnt %0d expected %b cnt %0d",
                     outs, stall_cnt, 6'b111000, exp_cnt);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL mid_reset_outs got %b expected %b", outs, 6'b000000);
        end
        tests_run++;
        if (stall_cnt !== 32'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_cnt got %0d expected 0", stall_cnt);
        end
        exp_cnt = 32'd0;
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        // A leftover MEM_WAIT would hold here since mem_ack is low
        #1;
        tests_run++;
        if (outs !== 6'b000000) begin
            tests_failed++;
            $display("FAIL post_reset_idle_outs got %b expected %b", outs, 6'b000000);
        end
        next_cycle();
        tests_run++;
        if (stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL post_reset_cnt got %0d expected %0d", stall_cnt, exp_cnt);
        end
    endtask

`ifdef PIPE_CTRL_TIMEOUT_EN
    task test_timeout;
        clear_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (outs !== 6'b111000) begin
                tests_failed++;
                $display("FAIL timeout_wait_outs cycle %0d got %b expected %b", i, outs, 6'b111000);
            end
            next_cycle();
            exp_cnt = exp_cnt + 32'd1;
        end
        #1;
        tests_run++;
        if (outs !== 6'b000001) begin
            tests_failed++;
            $display("FAIL timeout_fire_outs got %b expected %b", outs, 6'b000001);
        end
        next_cycle();
        clear_inputs();
        #1;
        tests_run++;
        if (outs !== 6'b000000 || stall_cnt !== exp_cnt) begin
            tests_failed++;
            $display("FAIL timeout_after got outs %b cnt %0d expected %b cnt %0d",
                     outs, stall_cnt, 6'b000000, exp_cnt);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = 32'd0;
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_load_use_x0();
        test_branch();
        test_branch_vs_load_use();
        test_mem_wait();
        test_mem_ack_same_cycle();
        test_branch_during_wait();
        test_reset_mid_wait();
`ifdef PIPE_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller that drives the `hold` and flush inputs of the IF/ID (`fliop1`), ID/EX (`fliop2`) and EX/MEM (`fliop3`) pipeline registers.

- Detects load-use hazards, taken branches and jumps, and data-memory wait states.
- Sequences the resulting stalls and bubbles.
- Counts stall cycles for performance monitoring.
- Sits beside the pipeline: it consumes decode and execute stage fields, and every pipeline register consumes its outputs.

## Interface
Parameters:
- `TIMEOUT`, default 255: MEM_WAIT cycles allowed before the timeout fires (used only with `PIPE_CTRL_TIMEOUT_EN`).
- `CNT_WIDTH`, default 8: width of the MEM_WAIT cycle counter; must satisfy 2^CNT_WIDTH > `TIMEOUT`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs1_addr`  in  `REG_ADDR_WIDTH`  rs1 address of the instruction in ID.
- `id_rs2_addr`  in  `REG_ADDR_WIDTH`  rs2 address of the instruction in ID.
- `id_rs1_ren`  in  1  ID instruction reads rs1.
- `id_rs2_ren`  in  1  ID instruction reads rs2.
- `ex_rd_waddr`  in  `REG_ADDR_WIDTH`  rd of the instruction in EX (`rd_waddr_o` of `fliop2`).
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_br_taken`  in  1  EX resolved a taken branch or jump.
- `mem_req`  in  1  MEM stage has a data-memory request outstanding.
- `mem_ack`  in  1  data memory completes the request this cycle.
- `hold_if`  out  1  freeze the PC and `fliop1`.
- `hold_id`  out  1  freeze `fliop2`.
- `hold_ex`  out  1  freeze `fliop3`.
- `flush_id`  out  1  load a NOP into `fliop1`.
- `flush_ex`  out  1  load a NOP/bubble into `fliop2`.
- `stall_cnt`  out  32  total cycles with `hold_if` = 1.
- `mem_err`  out  1  one-cycle pulse on memory timeout.

## Operation
States:
- IDLE: normal flow.
- MEM_WAIT: a data-memory access is stalled.

Hazard sources, in priority order (highest first):
- Memory stall: `mem_req`=1 and `mem_ack`=0.
  - Asserts `hold_if`, `hold_id` and `hold_ex` in the same cycle (Mealy).
  - Flushes are forced to 0.
  - IDLE moves to MEM_WAIT.
  - In MEM_WAIT, the holds stay asserted while `mem_ack`=0.
  - On the cycle `mem_ack`=1, all holds drop in that same cycle and the next state is IDLE.
- Taken branch: `ex_br_taken`=1 and no memory stall.
  - Asserts `flush_id`=1 and `flush_ex`=1 for exactly that cycle; no holds.
  - A branch that arrives during a memory stall is not lost. EX is frozen, so `ex_br_taken` stays high and the flush fires on the release cycle.
- Load-use: `ex_is_load`=1, `ex_rd_waddr`≠0, and (`id_rs1_ren` with rs1==rd, or `id_rs2_ren` with rs2==rd).
  - Asserts `hold_if`=1, `hold_id`=1 and `flush_ex`=1 for that cycle (one bubble).
  - The next cycle the load is in MEM and the hazard clears naturally.
  - x0 never creates a hazard.
- Otherwise all holds and flushes are 0.

`stall_cnt` behaviour:
- Increments by 1 on every rising edge where `hold_if`=1.
- Wraps from 0xFFFF_FFFF to 0.
- Never saturates.

## Timing
- All holds and flushes are combinational from the current state and inputs, with zero-cycle latency. The consumer pipeline registers sample them on the same edge.
- A load-use hazard costs exactly 1 stall cycle. A taken branch costs 2 squashed instructions and 0 stall cycles.
- A memory stall costs N stall cycles, where N is the number of cycles before `mem_ack`. An ack in the same cycle as the request costs 0 stalls and never enters MEM_WAIT.
- Reset asserted, at any time including mid-MEM_WAIT:
  - Immediately returns the state to IDLE.
  - Clears `stall_cnt` and the MEM_WAIT counter to 0.
  - Forces all holds, flushes and `mem_err` to 0 while `rst`=0.
- Simultaneous load-use and taken branch: the branch wins. `flush_id`=`flush_ex`=1 and no hold.

## Configuration
- `PIPE_CTRL_TIMEOUT_EN` defined:
  - A `CNT_WIDTH` counter clears on MEM_WAIT entry and increments each cycle in MEM_WAIT.
  - When it reaches `TIMEOUT` with `mem_ack`=0, `mem_err` pulses for 1 cycle, all holds drop that cycle, and the state returns to IDLE.
- Not defined:
  - No counter exists.
  - `mem_err` is tied to 0.
  - MEM_WAIT waits indefinitely for `mem_ack`.

## Structure
- The shared defines file supplies:
  - `REG_ADDR_WIDTH`.
  - `HOLD` / `NOHOLD` (1/0) and `RST` (0).
  - State encodings `PC_IDLE` and `PC_MEM_WAIT`.
  - `PIPE_CTRL_TIMEOUT_EN`, left commented out by default.
- One natural sub-module, `hazard_detect`: the pure combinational load-use compare, producing `lu_hazard`. The FSM, the counters and the priority mux live in `pipe_ctrl`.

## Test plan
- Load-use:
  - Stimulus: `ex_is_load`=1, `ex_rd_waddr`=5, `id_rs2_ren`=1, `id_rs2_addr`=5 for 1 cycle.
  - Response: `hold_if`=`hold_id`=`flush_ex`=1 for 1 cycle; `stall_cnt` goes 0→1.
  - Repeat with rd=0: no hold.
- Taken branch:
  - Stimulus: `ex_br_taken`=1 for 1 cycle.
  - Response: `flush_id`=`flush_ex`=1 for 1 cycle, holds 0, `stall_cnt` unchanged.
- Memory wait:
  - Stimulus: `mem_req`=1, `mem_ack` low for 3 cycles then high.
  - Response: all holds =1 for exactly 3 cycles, 0 on the ack cycle; state back in IDLE; `stall_cnt`=3.
- Branch during memory wait:
  - Stimulus: `ex_br_taken`=1 held through a 2-cycle memory wait.
  - Response: no flush during the wait; both flushes =1 on the ack cycle.
- Reset mid-MEM_WAIT:
  - Stimulus: drop `rst` while in MEM_WAIT with `stall_cnt`=7.
  - Response: outputs immediately 0, `stall_cnt`=0; after release with `mem_req`=0, state is IDLE.
- Timeout (with `PIPE_CTRL_TIMEOUT_EN`, `TIMEOUT`=4):
  - Stimulus: `mem_req`=1, `mem_ack`=0 held.
  - Response: `mem_err` pulses once on the 5th stalled cycle, holds drop that cycle, state returns to IDLE.
